// File: rtl/oscill_capture_if.sv
// Signal bundle between the oscilloscope capture buffer and its environment:
// sample stream, trigger/arm control, frame readout port and status.
interface oscill_capture_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
);
   logic              smp_valid;
   logic [DATA_W-1:0] smp_data;
   logic              trig;
   logic              arm;
   logic [ADDR_W-1:0] pre_len;
   logic              rd_req;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_last;
   logic              busy;
   logic              done;
   logic [2:0]        cap_state;

   modport master (
      output smp_valid, smp_data, trig, arm, pre_len, rd_req,
      input  rd_data, rd_valid, rd_last, busy, done, cap_state
   );

   modport slave (
      input  smp_valid, smp_data, trig, arm, pre_len, rd_req,
      output rd_data, rd_valid, rd_last, busy, done, cap_state
   );
endinterface

// File: rtl/oscill_capture.sv
// Trigger-driven ring-buffer waveform capture with programmable pre-trigger
// length. Optional auto-trigger timeout is enabled by defining AUTO_TRIG_EN.
module oscill_capture #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 65535
) (
   input  logic            clk,
   input  logic            rst_n,
   oscill_capture_if.slave cap
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRE_FILL  = 3'd1,
      WAIT_TRIG = 3'd2,
      POST      = 3'd3,
      READY     = 3'd4,
      READOUT   = 3'd5
   } state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] pre_r;
   logic [ADDR_W-1:0] fill_cnt;
   logic [ADDR_W-1:0] post_cnt;
   logic [ADDR_W-1:0] trig_addr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] rd_cnt;
   logic              trig_pend;
   logic [DATA_W-1:0] rd_data_r;
   logic              rd_valid_r;
   logic              rd_last_r;

   logic              capturing;
   logic              arm_restart;
   logic              wr_en;
   logic              trig_hit;
   logic              rd_issue;
   logic              auto_fire;
   logic [ADDR_W-1:0] fill_nxt;
   logic [ADDR_W-1:0] start_addr;

   // Read port: each cycle with rd_req high in READOUT issues one read; the
   // matching rd_valid pulses exactly one cycle later. There is no back-pressure.
   always_comb begin
      capturing   = (state == PRE_FILL) || (state == WAIT_TRIG) || (state == POST);
      arm_restart = cap.arm && (state != READOUT);
      wr_en       = cap.smp_valid && capturing && !cap.arm;
      trig_hit    = wr_en && (state == WAIT_TRIG) && (trig_pend || cap.trig || auto_fire);
      rd_issue    = (state == READOUT) && cap.rd_req;
      fill_nxt    = fill_cnt + 1'b1;
      start_addr  = trig_addr - pre_r;
   end

`ifdef AUTO_TRIG_EN
   localparam int TO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] auto_cnt;

   assign auto_fire = (auto_cnt == TO_W'(TIMEOUT));

   // Held at zero outside WAIT_TRIG, so every entry starts a fresh count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         auto_cnt <= '0;
      end else if (arm_restart || (state != WAIT_TRIG)) begin
         auto_cnt <= '0;
      end else if (wr_en && !auto_fire) begin
         auto_cnt <= auto_cnt + 1'b1;
      end
   end
`else
   logic unused_timeout;
   assign auto_fire      = 1'b0;
   assign unused_timeout = (TIMEOUT < 0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (arm_restart) begin
         state_nxt = (cap.pre_len == '0) ? WAIT_TRIG : PRE_FILL;
      end else begin
         case (state)
            IDLE: state_nxt = IDLE;
            PRE_FILL: begin
               if (wr_en && (fill_nxt == pre_r)) state_nxt = WAIT_TRIG;
            end
            WAIT_TRIG: begin
               if (trig_hit) state_nxt = (pre_r == '1) ? READY : POST;
            end
            POST: begin
               if (wr_en && (post_cnt == ADDR_W'(1))) state_nxt = READY;
            end
            READY: begin
               if (cap.rd_req) state_nxt = READOUT;
            end
            READOUT: begin
               if (rd_issue && (rd_cnt == '1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= cap.smp_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         pre_r      <= '0;
         fill_cnt   <= '0;
         post_cnt   <= '0;
         trig_addr  <= '0;
         rd_ptr     <= '0;
         rd_cnt     <= '0;
         trig_pend  <= 1'b0;
         rd_data_r  <= '0;
         rd_valid_r <= 1'b0;
         rd_last_r  <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;

         rd_valid_r <= rd_issue;
         rd_last_r  <= rd_issue && (rd_cnt == '1);
         if (rd_issue) rd_data_r <= mem[rd_ptr];

         if (arm_restart) begin
            pre_r     <= cap.pre_len;
            fill_cnt  <= '0;
            trig_pend <= 1'b0;
         end else begin
            case (state)
               PRE_FILL: begin
                  if (wr_en) fill_cnt <= fill_nxt;
               end
               WAIT_TRIG: begin
                  // post_cnt holds the number of post-trigger samples still to
                  // write: DEPTH-1-pre_r, which is simply ~pre_r.
                  if (trig_hit) begin
                     trig_addr <= wr_ptr;
                     post_cnt  <= ~pre_r;
                     trig_pend <= 1'b0;
                  end else if (cap.trig) begin
                     trig_pend <= 1'b1;
                  end
               end
               POST: begin
                  if (wr_en) post_cnt <= post_cnt - 1'b1;
               end
               READY: begin
                  if (cap.rd_req) begin
                     rd_ptr <= start_addr;
                     rd_cnt <= '0;
                  end
               end
               READOUT: begin
                  if (rd_issue) begin
                     rd_ptr <= rd_ptr + 1'b1;
                     rd_cnt <= rd_cnt + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign cap.rd_data   = rd_data_r;
   assign cap.rd_valid  = rd_valid_r;
   assign cap.rd_last   = rd_last_r;
   assign cap.busy      = capturing;
   assign cap.done      = (state == READY);
   assign cap.cap_state = state;

endmodule

// File: tb/tb_oscill_capture.sv
// Directed bench for oscill_capture with a 16-deep frame; the auto-trigger
// scenario is compiled in when AUTO_TRIG_EN is defined.
module tb_oscill_capture;
   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int         last_cnt = 0;
   int         last_idx = -1;

   always #5 clk = ~clk;

   oscill_capture_if #(.DATA_W(8), .ADDR_W(4)) ifc ();

   oscill_capture #(.DATA_W(8), .ADDR_W(4), .TIMEOUT(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cap   (ifc.slave)
   );

   always @(negedge clk) begin
      if (ifc.rd_valid === 1'b1) begin
         got_q.push_back(ifc.rd_data);
         if (ifc.rd_last === 1'b1) begin
            last_cnt++;
            last_idx = got_q.size() - 1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input logic sv, input logic [7:0] d, input logic tg,
                       input logic ar, input logic [3:0] pl, input logic rq);
      ifc.smp_valid = sv;
      ifc.smp_data  = d;
      ifc.trig      = tg;
      ifc.arm       = ar;
      ifc.pre_len   = pl;
      ifc.rd_req    = rq;
      @(posedge clk);
      #1;
   endtask

   task automatic arm_cap(input logic [3:0] pl);
      step(1'b0, 8'h00, 1'b0, 1'b1, pl, 1'b0);
   endtask

   task automatic feed(input int first, input int n, input int ta, input int tb, input bit gapped);
      logic t;
      for (int i = 0; i < n; i++) begin
         t = (i == ta) || (i == tb);
         if (gapped) begin
            step(1'b0, 8'h00, t, 1'b0, 4'd0, 1'b0);
            step(1'b1, 8'(first + i), 1'b0, 1'b0, 4'd0, 1'b0);
         end else begin
            step(1'b1, 8'(first + i), t, 1'b0, 4'd0, 1'b0);
         end
      end
   endtask

   task automatic readout(input bit pause, output bit timed_out);
      bit fin;
      fin = 1'b0;
      got_q.delete();
      last_cnt = 0;
      last_idx = -1;
      for (int c = 0; c < 200 && !fin; c++) begin
         step(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, pause ? 1'($urandom_range(0, 1)) : 1'b1);
         if (ifc.cap_state == 3'd0) fin = 1'b1;
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
      timed_out = !fin;
   endtask

   task automatic test_reset;
      ifc.smp_valid = 0; ifc.smp_data = 0; ifc.trig = 0;
      ifc.arm = 0; ifc.pre_len = 0; ifc.rd_req = 0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({ifc.rd_data, ifc.rd_valid, ifc.rd_last, ifc.busy, ifc.done, ifc.cap_state} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got data=%h v=%b l=%b busy=%b done=%b st=%0d want all 0",
                  ifc.rd_data, ifc.rd_valid, ifc.rd_last, ifc.busy, ifc.done, ifc.cap_state);
      end
      rst_n = 1'b1;
      got_q.delete();
      repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1);
      n_tests++;
      if (got_q.size() != 0 || ifc.cap_state !== 3'd0) begin
         n_fail++;
         $display("FAIL idle_rd_req: got %0d reads state %0d want 0 reads state 0", got_q.size(), ifc.cap_state);
      end
   endtask

   task automatic test_basic;
      bit to;
      arm_cap(4'd4);
      n_tests++;
      if (ifc.cap_state !== 3'd1 || ifc.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_arm: got state %0d busy %b want 1 1", ifc.cap_state, ifc.busy);
      end
      feed(0, 21, 10, -1, 1'b0);
      n_tests++;
      if (ifc.cap_state !== 3'd3 || ifc.done !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_post: got state %0d done %b want 3 0", ifc.cap_state, ifc.done);
      end
      feed(21, 1, -1, -1, 1'b0);
      n_tests++;
      if (ifc.cap_state !== 3'd4 || ifc.done !== 1'b1 || ifc.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_done: got state %0d done %b busy %b want 4 1 0", ifc.cap_state, ifc.done, ifc.busy);
      end
      feed(99, 1, -1, -1, 1'b0);
      exp_q.delete();
      for (int k = 6; k <= 21; k++) exp_q.push_back(8'(k));
      readout(1'b0, to);
      n_tests++;
      if (to || got_q.size() != 16) begin
         n_fail++;
         $display("FAIL basic_count: got %0d reads timeout %b want 16 0", got_q.size(), to);
      end
      for (int k = 0; k < 16; k++) begin
         n_tests++;
         if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
            n_fail++;
            $display("FAIL basic_data[%0d]: got %0d want %0d", k, (k < got_q.size()) ? got_q[k] : 8'hxx, exp_q[k]);
         end
      end
      n_tests++;
      if (last_cnt != 1 || last_idx != 15) begin
         n_fail++;
         $display("FAIL basic_last: got count %0d index %0d want 1 15", last_cnt, last_idx);
      end
   endtask

   task automatic test_early_trig;
      bit to;
      arm_cap(4'd8);
      feed(0, 20, 3, 12, 1'b0);
      n_tests++;
      if (ifc.cap_state !== 3'd4) begin
         n_fail++;
         $display("FAIL early_ready: got state %0d want 4", ifc.cap_state);
      end
      exp_q.delete();
      for (int k = 4; k <= 19; k++) exp_q.push_back(8'(k));
      readout(1'b0, to);
      n_tests++;
      if (to || got_q.size() != 16) begin
         n_fail++;
         $display("FAIL early_count: got %0d reads timeout %b want 16 0", got_q.size(), to);
      end
      for (int k = 0; k < 16; k++) begin
         n_tests++;
         if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
            n_fail++;
            $display("FAIL early_data[%0d]: got %0d want %0d", k, (k < got_q.size()) ? got_q[k] : 8'hxx, exp_q[k]);
         end
      end
   endtask

   task automatic test_boundaries;
      bit to;
      arm_cap(4'd0);
      n_tests++;
      if (ifc.cap_state !== 3'd2) begin
         n_fail++;
         $display("FAIL pre0_wait: got state %0d want 2", ifc.cap_state);
      end
      feed(0, 16, 0, -1, 1'b0);
      n_tests++;
      if (ifc.cap_state !== 3'd4) begin
         n_fail++;
         $display("FAIL pre0_ready: got state %0d want 4", ifc.cap_state);
      end
      readout(1'b0, to);
      n_tests++;
      if (to || got_q.size() != 16 || got_q[0] !== 8'd0 || got_q[15] !== 8'd15) begin
         n_fail++;
         $display("FAIL pre0_frame: got %0d reads first %0d last %0d want 16 0 15",
                  got_q.size(), got_q[0], got_q[got_q.size()-1]);
      end

      arm_cap(4'd15);
      feed(0, 20, -1, -1, 1'b0);
      n_tests++;
      if (ifc.cap_state !== 3'd2) begin
         n_fail++;
         $display("FAIL pre15_wait: got state %0d want 2", ifc.cap_state);
      end
      feed(20, 1, 0, -1, 1'b0);
      n_tests++;
      if (ifc.cap_state !== 3'd4) begin
         n_fail++;
         $display("FAIL pre15_ready: got state %0d want 4", ifc.cap_state);
      end
      exp_q.delete();
      for (int k = 5; k <= 20; k++) exp_q.push_back(8'(k));
      readout(1'b0, to);
      n_tests++;
      if (to || got_q.size() != 16) begin
         n_fail++;
         $display("FAIL pre15_count: got %0d reads timeout %b want 16 0", got_q.size(), to);
      end
      for (int k = 0; k < 16; k++) begin
         n_tests++;
         if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
            n_fail++;
            $display("FAIL pre15_data[%0d]: got %0d want %0d", k, (k < got_q.size()) ? got_q[k] : 8'hxx, exp_q[k]);
         end
      end
   endtask

   task automatic test_gapped;
      bit to;
      arm_cap(4'd4);
      feed(0, 22, 10, -1, 1'b1);
      n_tests++;
      if (ifc.cap_state !== 3'd4) begin
         n_fail++;
         $display("FAIL gap_ready: got state %0d want 4", ifc.cap_state);
      end
      exp_q.delete();
      for (int k = 6; k <= 21; k++) exp_q.push_back(8'(k));
      readout(1'b1, to);
      n_tests++;
      if (to || got_q.size() != 16) begin
         n_fail++;
         $display("FAIL gap_count: got %0d reads timeout %b want 16 0", got_q.size(), to);
      end
      for (int k = 0; k < 16; k++) begin
         n_tests++;
         if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
            n_fail++;
            $display("FAIL gap_data[%0d]: got %0d want %0d", k, (k < got_q.size()) ? got_q[k] : 8'hxx, exp_q[k]);
         end
      end
      n_tests++;
      if (last_cnt != 1 || last_idx != 15) begin
         n_fail++;
         $display("FAIL gap_last: got count %0d index %0d want 1 15", last_cnt, last_idx);
      end
   endtask

   task automatic test_abort_reset;
      arm_cap(4'd4);
      feed(0, 14, 10, -1, 1'b0);
      n_tests++;
      if (ifc.cap_state !== 3'd3) begin
         n_fail++;
         $display("FAIL abort_post: got state %0d want 3", ifc.cap_state);
      end
      arm_cap(4'd2);
      n_tests++;
      if (ifc.cap_state !== 3'd1 || ifc.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_rearm: got state %0d busy %b want 1 1", ifc.cap_state, ifc.busy);
      end
      feed(100, 19, 5, -1, 1'b0);
      n_tests++;
      if (ifc.cap_state !== 3'd4) begin
         n_fail++;
         $display("FAIL abort_ready: got state %0d want 4", ifc.cap_state);
      end
      got_q.delete();
      repeat (6) step(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({ifc.rd_data, ifc.rd_valid, ifc.rd_last, ifc.busy, ifc.done, ifc.cap_state} !== 16'h0) begin
         n_fail++;
         $display("FAIL async_reset: got data=%h v=%b l=%b busy=%b done=%b st=%0d want all 0",
                  ifc.rd_data, ifc.rd_valid, ifc.rd_last, ifc.busy, ifc.done, ifc.cap_state);
      end
      n_tests++;
      if (got_q.size() != 4 || got_q[0] !== 8'd103 || got_q[3] !== 8'd106) begin
         n_fail++;
         $display("FAIL abort_partial: got %0d reads first %0d want 4 reads 103..106", got_q.size(), got_q[0]);
      end
      got_q.delete();
      repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1);
      rst_n = 1'b1;
      repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1);
      n_tests++;
      if (got_q.size() != 0 || ifc.cap_state !== 3'd0) begin
         n_fail++;
         $display("FAIL post_reset_quiet: got %0d reads state %0d want 0 0", got_q.size(), ifc.cap_state);
      end
   endtask

`ifdef AUTO_TRIG_EN
   task automatic test_auto_trig;
      bit to;
      arm_cap(4'd2);
      feed(0, 7, -1, -1, 1'b0);
      n_tests++;
      if (ifc.cap_state !== 3'd2) begin
         n_fail++;
         $display("FAIL auto_wait: got state %0d want 2", ifc.cap_state);
      end
      feed(7, 1, -1, -1, 1'b0);
      n_tests++;
      if (ifc.cap_state !== 3'd3) begin
         n_fail++;
         $display("FAIL auto_fire: got state %0d want 3", ifc.cap_state);
      end
      feed(8, 12, -1, -1, 1'b0);
      n_tests++;
      if (ifc.done !== 1'b0) begin
         n_fail++;
         $display("FAIL auto_early_done: got done %b want 0", ifc.done);
      end
      feed(20, 1, -1, -1, 1'b0);
      n_tests++;
      if (ifc.done !== 1'b1) begin
         n_fail++;
         $display("FAIL auto_done: got done %b want 1", ifc.done);
      end
      exp_q.delete();
      for (int k = 5; k <= 20; k++) exp_q.push_back(8'(k));
      readout(1'b0, to);
      for (int k = 0; k < 16; k++) begin
         n_tests++;
         if (to || k >= got_q.size() || got_q[k] !== exp_q[k]) begin
            n_fail++;
            $display("FAIL auto_data[%0d]: got %0d want %0d", k, (k < got_q.size()) ? got_q[k] : 8'hxx, exp_q[k]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_early_trig();
      test_boundaries();
      test_gapped();
      test_abort_reset();
`ifdef AUTO_TRIG_EN
      test_auto_trig();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
